// File: rtl/sar_capture_pkg.sv
// Shared types and constants for the SAR ADC sample-capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sar_capture_pkg;

  // Capture FSM: ARMED waits for EOC low so a conversion already in flight
  // when capture is enabled is never taken half-way through.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } cap_state_e;

  // Number of captured codes folded into one word by the optional averager.
  localparam int AVG_LEN = 4;

endpackage

// File: rtl/sar_sync_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured ADC codes.
// Latency: a pushed word is visible on o_rdata the cycle after the push edge.
// Backpressure: a push is refused when full unless a pop happens on the same edge.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset (clears pointers)
//   i_push, i_wdata     write request and data
//   i_pop               read request (ignored when empty)
//   o_rdata             head entry, 0 while empty
//   o_full, o_empty     occupancy flags
//   o_level             current occupancy, 0..DEPTH
module sar_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop_en;
  logic             w_push_en;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign w_pop_en  = i_pop & ~o_empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push_en = i_push & (~o_full | w_pop_en);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only observable once written.
  always_ff @(posedge i_clk) begin
    if (w_push_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/sar_sample_capture.sv
// Captures one SAR ADC code per EOC rising edge into a FIFO and streams it out (optional 4-sample averaging under SAR_CAPTURE_AVG_EN).
// Latency: code appears on m_data/m_valid one cycle after the EOC rising-edge capture.
// Backpressure: m_ready low lets the FIFO fill; a capture arriving when full with no pop is dropped and sets sticky overflow.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   enable                   capture enable (FIFO stays drainable when low)
//   adc_data, adc_eoc        ADC code and end-of-conversion
//   m_data, m_valid, m_ready output stream, transfer on m_valid & m_ready
//   level                    FIFO occupancy
//   overflow, clear_ovf      sticky drop flag and its clear (a new drop wins)
//   sample_count             words accepted into the FIFO since reset, wraps
module sar_sample_capture #(
  parameter int NUM_BITS   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_BITS-1:0]           adc_data,
  input  logic                          adc_eoc,
  output logic [NUM_BITS-1:0]           m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic [CNT_W-1:0]              sample_count
);

  import sar_capture_pkg::*;

  logic                r_eoc_q;
  cap_state_e          r_state;
  cap_state_e          w_state_nxt;
  logic                w_rise;
  logic                w_cap;
  logic                w_push_req;
  logic [NUM_BITS-1:0] w_push_dat;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_drop;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_count;

  // A long EOC pulse yields a single capture: only its rising edge counts.
  assign w_rise = adc_eoc & ~r_eoc_q;
  assign w_cap  = (r_state == RUN) & w_rise;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = ARMED;
      ARMED: begin
        if (!enable)       w_state_nxt = IDLE;
        else if (!adc_eoc) w_state_nxt = RUN;
      end
      RUN:     if (!enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SAR_CAPTURE_AVG_EN
  logic [NUM_BITS+1:0] r_acc;
  logic [NUM_BITS+1:0] w_sum;
  logic [1:0]          r_avg_cnt;
  logic                w_avg_last;

  // The 4th code is added combinationally so the average is pushed on the
  // same edge it is captured.
  assign w_sum      = r_acc + {2'b00, adc_data};
  assign w_avg_last = (r_avg_cnt == 2'(AVG_LEN - 1));
  assign w_push_req = w_cap & enable & w_avg_last;
  assign w_push_dat = w_sum[NUM_BITS+1:2];

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_acc     <= '0;
      r_avg_cnt <= '0;
    end else if (w_cap) begin
      if (w_avg_last) begin
        r_acc     <= '0;
        r_avg_cnt <= '0;
      end else begin
        r_acc     <= w_sum;
        r_avg_cnt <= r_avg_cnt + 2'd1;
      end
    end
  end
`else
  assign w_push_req = w_cap;
  assign w_push_dat = adc_data;
`endif

  assign m_valid = ~w_empty;
  assign w_pop   = ~w_empty & m_ready;
  assign w_drop  = w_push_req & w_full & ~w_pop;

  sar_sync_fifo #(
    .WIDTH (NUM_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push_req),
    .i_wdata (w_push_dat),
    .i_pop   (w_pop),
    .o_rdata (m_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_eoc_q <= 1'b0;
      r_state <= IDLE;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      r_eoc_q <= adc_eoc;
      r_state <= w_state_nxt;
      // A drop on the same edge as a clear keeps the flag set.
      if (w_drop)         r_ovf <= 1'b1;
      else if (clear_ovf) r_ovf <= 1'b0;
      if (w_push_req && !w_drop) r_count <= r_count + CNT_W'(1);
    end
  end

  assign overflow     = r_ovf;
  assign sample_count = r_count;

endmodule

// File: tb/tb_sar_sample_capture.sv
// Randomized scoreboard bench for sar_sample_capture.
// Latency: expects each accepted code at the stream head one cycle after capture.
// Backpressure: drives m_ready low/random to exercise full, drop and overflow.
module tb_sar_sample_capture;

  localparam int NB = 4;
  localparam int FD = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [NB-1:0] adc_data = '0;
  logic          adc_eoc = 1'b0;
  logic [NB-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [3:0]    level;
  logic          overflow;
  logic          clear_ovf = 1'b0;
  logic [CW-1:0] sample_count;

  always #5 clk = ~clk;

  sar_sample_capture #(
    .NUM_BITS   (NB),
    .FIFO_DEPTH (FD),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .adc_data     (adc_data),
    .adc_eoc      (adc_eoc),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf),
    .sample_count (sample_count)
  );

  int            n_checks = 0;
  int            n_pass = 0;
  logic [NB-1:0] exp_q[$];
  int            mocc = 0;
  bit            movf = 1'b0;
  logic [CW-1:0] mcount = '0;
  bit            cap_flag = 1'b0;
  logic [NB-1:0] cap_code = '0;
  bit            mon_en = 1'b0;
  bit            rnd_rdy = 1'b0;
  int            avg_sum = 0;
  int            avg_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a conversion flagged as capturable becomes a word
  // (directly, or every 4th as the truncated mean); the word is queued if
  // there is room or the consumer takes one this cycle, else it is lost.
  always @(posedge clk) begin : model
    bit            pop;
    bit            have;
    logic [NB-1:0] w;
    if (!rst_n) begin
      exp_q.delete();
      mocc    = 0;
      movf    = 1'b0;
      mcount  = '0;
      avg_sum = 0;
      avg_n   = 0;
    end else begin
      pop  = m_ready && (mocc > 0);
      have = 1'b0;
      w    = '0;
`ifdef SAR_CAPTURE_AVG_EN
      if (!enable) begin
        avg_sum = 0;
        avg_n   = 0;
      end else if (cap_flag) begin
        avg_sum += int'(cap_code);
        avg_n++;
        if (avg_n == 4) begin
          have    = 1'b1;
          w       = NB'(avg_sum / 4);
          avg_sum = 0;
          avg_n   = 0;
        end
      end
`else
      if (cap_flag) begin
        have = 1'b1;
        w    = cap_code;
      end
`endif
      if (clear_ovf) movf = 1'b0;
      if (have) begin
        if (mocc < FD || pop) begin
          exp_q.push_back(w);
          mocc++;
          mcount++;
        end else begin
          movf = 1'b1;
        end
      end
      if (pop) mocc--;
    end
  end

  // Monitor: compares the stream head and status outputs every cycle,
  // retiring the expected head whenever a transfer takes place.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_valid", 32'(m_valid), 32'(mocc != 0));
      if (exp_q.size() > 0) begin
        chk("m_data", 32'(m_data), 32'(exp_q[0]));
        if (m_ready) void'(exp_q.pop_front());
      end else begin
        chk("m_data_empty", 32'(m_data), 32'd0);
      end
      chk("level", 32'(level), 32'(mocc));
      chk("overflow", 32'(overflow), 32'(movf));
      chk("sample_count", 32'(sample_count), 32'(mcount));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cap_flag  = 1'b0;
      clear_ovf = 1'b0;
      if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // One conversion: EOC high for w cycles then low for g cycles.
  task automatic conv(input logic [NB-1:0] code, input bit expect_cap,
                      input int w = 1, input int g = 2);
    adc_data = code;
    adc_eoc  = 1'b1;
    cap_flag = expect_cap;
    cap_code = code;
    tick(w);
    adc_eoc = 1'b0;
    tick(g);
  endtask

  initial begin
    rst_n = 1'b0;
    tick(2);
    mon_en = 1'b1;
    tick(2);
    rst_n = 1'b1;

    // Long EOC pulse captured exactly once.
    enable = 1'b1;
    tick(3);
    conv(4'hA, 1'b1, 3, 3);

    // Enable rising during a conversion ignores it.
    enable = 1'b0;
    tick(2);
    adc_data = 4'h3;
    adc_eoc  = 1'b1;
    tick(1);
    enable = 1'b1;
    tick(3);
    adc_eoc = 1'b0;
    tick(3);
    conv(4'h5, 1'b1, 1, 3);

    // Stall consumer: fill, overflow, drain in order, clear flag.
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) conv(NB'(i), 1'b1, 1 + (i % 3), 1);
    m_ready = 1'b1;
    tick(12);
    clear_ovf = 1'b1;
    tick(2);

    // Full FIFO with push and pop on the same edge.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) conv(NB'(i + 7), 1'b1, 1, 1);
    m_ready = 1'b1;
    conv(4'hF, 1'b1, 1, 1);
    conv(4'h6, 1'b1, 2, 1);
    tick(12);

`ifdef SAR_CAPTURE_AVG_EN
    // Averaging: 3,4,5,7 -> 4; then a partial set discarded by disable.
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(3);
    conv(4'h3, 1'b1);
    conv(4'h4, 1'b1);
    conv(4'h5, 1'b1);
    conv(4'h7, 1'b1);
    conv(4'h9, 1'b1);
    conv(4'hB, 1'b1);
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(3);
`endif

    // Randomized traffic with random backpressure and overflow clears.
    rnd_rdy = 1'b1;
    repeat (150) begin
      if ($urandom_range(0, 9) == 0) clear_ovf = 1'b1;
      conv(NB'($urandom), 1'b1, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    end
    rnd_rdy = 1'b0;
    m_ready = 1'b1;
    tick(12);

    // Mid-stream reset with a full FIFO and overflow set.
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) conv(NB'($urandom), 1'b1, 1, 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick(4);
    conv(4'hC, 1'b1, 2, 2);

    // Disable stops capture but the FIFO still drains.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) conv(NB'(i + 1), 1'b1, 1, 1);
    enable = 1'b0;
    tick(2);
    conv(4'h7, 1'b0, 1, 2);
    conv(4'h9, 1'b0, 2, 2);
    m_ready = 1'b1;
    tick(12);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick(1);
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
